// File: rtl/core_pkg.sv
// Shared vector-core types: VRF writeback beat format, instruction IDs and
// the writeback arbiter state encoding.
package core_pkg;

    localparam int unsigned NrVFU     = 4;
    localparam int unsigned InsnIDNum = 8;
    localparam int unsigned VrfAddrW  = 5;
    localparam int unsigned VrfDataW  = 32;

    typedef logic [$clog2(InsnIDNum)-1:0] insn_id_t;
    typedef logic [VrfAddrW-1:0]          vrf_addr_t;
    typedef logic [VrfDataW-1:0]          vrf_data_t;
    typedef logic [VrfDataW/8-1:0]        vrf_strb_t;

    typedef struct packed {
        vrf_addr_t waddr;
        vrf_data_t wdata;
        vrf_strb_t wbe;
        insn_id_t  insn_id;
        logic      last;
    } vrf_wb_req_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } wb_arb_state_e;

endpackage

// File: rtl/vrf_wb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping from N-1 back to 0.
module rr_picker #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            any_o
);

    always_comb begin
        int unsigned cand;
        cand  = 0;
        any_o = 1'b0;
        idx_o = '0;
        gnt_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(ptr_i) + i) % N;
            if (!any_o && req_i[IdxW'(cand)]) begin
                any_o = 1'b1;
                idx_o = IdxW'(cand);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            gnt_o[i] = any_o && (idx_o == IdxW'(i));
        end
    end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Arbitrates VFU writeback beats onto the single VRF write port. Bursts are
// locked to one requester; new instructions are gated by commit permission.
module vrf_wb_arbiter
    import core_pkg::*;
#(
    parameter int unsigned NrReq = NrVFU
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NrReq-1:0]     wb_valid_i,
    output logic [NrReq-1:0]     wb_ready_o,
    input  vrf_wb_req_t          wb_req_i [NrReq],
    input  logic [InsnIDNum-1:0] insn_can_commit_i,
    output logic                 vrf_wvalid_o,
    input  logic                 vrf_wready_i,
    output vrf_wb_req_t          vrf_wreq_o,
    output logic                 wb_done_o,
    output insn_id_t             wb_done_id_o
);

    localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;
    typedef logic [IdxW-1:0] idx_t;

    wb_arb_state_e state_q, state_d;
    idx_t          rr_ptr_q, rr_ptr_d;
    idx_t          owner_q, owner_d;
    logic          wvalid_q, wvalid_d;
    vrf_wb_req_t   wreq_q, wreq_d;

    logic [NrReq-1:0] eligible;
    logic [NrReq-1:0] pick_gnt;
    logic [NrReq-1:0] gnt_vec;
    idx_t             pick_idx;
    idx_t             gnt_idx;
    logic             pick_any;
    logic             out_free;
    logic             accept;

    always_comb begin
        eligible = '0;
        for (int unsigned k = 0; k < NrReq; k++) begin
            eligible[k] = wb_valid_i[k] && insn_can_commit_i[wb_req_i[k].insn_id];
        end
    end

    rr_picker #(
        .N    (NrReq),
        .IdxW (IdxW)
    ) u_picker (
        .req_i (eligible),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Mid-burst only the owner may continue; commit permission was already
    // granted when its first beat went through.
    always_comb begin
        gnt_vec = '0;
        gnt_idx = pick_idx;
        if (state_q == IDLE) begin
            gnt_vec = pick_any ? pick_gnt : '0;
        end else begin
            gnt_idx          = owner_q;
            gnt_vec[owner_q] = wb_valid_i[owner_q];
        end
    end

    assign out_free   = !wvalid_q || vrf_wready_i;
    assign wb_ready_o = (out_free && rst_ni) ? gnt_vec : '0;
    assign accept     = |(wb_valid_i & wb_ready_o);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        wvalid_d = wvalid_q;
        wreq_d   = wreq_q;
        if (accept) begin
            wvalid_d = 1'b1;
            wreq_d   = wb_req_i[gnt_idx];
            if (wb_req_i[gnt_idx].last) begin
                state_d  = IDLE;
                rr_ptr_d = (gnt_idx == idx_t'(NrReq - 1)) ? '0 : idx_t'(gnt_idx + idx_t'(1));
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                owner_d = gnt_idx;
            end
        end else if (vrf_wready_i) begin
            wvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            wvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            wvalid_q <= wvalid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        wreq_q <= wreq_d;
    end

    assign vrf_wvalid_o = wvalid_q;
    assign vrf_wreq_o   = wreq_q;
    assign wb_done_o    = rst_ni && wvalid_q && vrf_wready_i && wreq_q.last;
    assign wb_done_id_o = wreq_q.insn_id;

endmodule
